// File: rtl/instr_fetch_unit_if.sv
// Bundle of fetch-stage signals: the instruction memory request/response
// bus, the downstream instruction handshake and the retire-time redirect.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            misalign;
  logic [31:0]     retire_cnt;

  // Fetch unit side: drives requests and the fetched instruction.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, misalign, retire_cnt,
    input  imem_rvalid, imem_rdata, instr_ready, pc_src, pc_target
  );

  // Environment side: memory and downstream decoder.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, misalign, retire_cnt,
    output imem_rvalid, imem_rdata, instr_ready, pc_src, pc_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one memory request per instruction, holds the returned word
// until the decoder retires it, then follows the retiring redirect.
// A misaligned taken redirect parks the unit in HALT until reset.
//
//   state | meaning
//   IDLE  | first cycle after reset release
//   REQ   | imem_req pulse, imem_addr = pc
//   WAIT  | waiting for imem_rvalid (no timeout)
//   VALID | instr presented, waiting for instr_ready
//   HALT  | misaligned redirect retired, no further fetches
module instr_fetch_unit #(
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     retire_cnt_q, retire_cnt_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] pc_plus4;
  logic            retire;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign retire   = instr_valid_q & bus.instr_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    retire_cnt_d  = retire_cnt_q;
    imem_req_d    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        imem_req_d = 1'b1;
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = VALID;
        end
      end
      VALID: begin
        if (retire) begin
          retire_cnt_d  = retire_cnt_q + 32'd1;
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          // A taken redirect to a non-word address stops fetching; pc keeps
          // the offending instruction's address for debug.
          if (bus.pc_src && (bus.pc_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d       = bus.pc_src ? bus.pc_target : pc_plus4;
            imem_req_d = 1'b1;
            state_d    = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; all outputs come straight from flops except pc_plus4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      retire_cnt_q  <= 32'd0;
      imem_req_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      retire_cnt_q  <= retire_cnt_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.misalign    = misalign_q;
  assign bus.retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a transaction table, hand-written reset and
// wrap sequences, and randomized transactions checked against a PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus ();
  instr_fetch_unit_if #(.XLEN(32)) bus2 ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 0;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          rdy;
    bit          src;
    logic [31:0] tgt;
    logic [31:0] pc;
    bit          halt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b0;
    bus.pc_src = 1'b0;
    bus2.imem_rvalid = 1'b0;
    bus2.instr_ready = 1'b0;
    bus2.pc_src = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_cnt", bus.retire_cnt, 32'd0);
    chk("rst_pc_plus4", bus.pc_plus4, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One fetch/retire transaction on the main instance.
  task automatic txn(input int lat, input logic [31:0] rdata, input int rdy,
                     input bit src, input logic [31:0] tgt,
                     input logic [31:0] exp_pc, input bit exp_halt);
    bit ok;
    wait_req(ok);
    chk("req_addr", bus.imem_addr, exp_pc);
    chk("valid_in_req", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    chk("req_pulse_len", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < lat; i++) begin
      bus.instr_ready = 1'($urandom);
      bus.pc_src = 1'($urandom);
      bus.pc_target = $urandom;
      @(negedge clk);
      chk("req_in_wait", 32'(bus.imem_req), 32'd0);
      chk("valid_in_wait", 32'(bus.instr_valid), 32'd0);
    end
    bus.instr_ready = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = rdata;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = $urandom;
    chk("valid_set", 32'(bus.instr_valid), 32'd1);
    chk("instr", bus.instr, rdata);
    chk("pc", bus.pc, exp_pc);
    chk("pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
    chk("cnt_before", bus.retire_cnt, exp_cnt);
    for (int i = 0; i < rdy; i++) begin
      bus.pc_src = 1'($urandom);
      bus.pc_target = $urandom;
      bus.imem_rvalid = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", bus.instr, rdata);
      chk("stall_pc", bus.pc, exp_pc);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      chk("stall_cnt", bus.retire_cnt, exp_cnt);
    end
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b1;
    bus.pc_src = src;
    bus.pc_target = tgt;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.pc_src = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("cnt_after", bus.retire_cnt, exp_cnt);
    chk("valid_clr", 32'(bus.instr_valid), 32'd0);
    chk("instr_nop", bus.instr, NOP);
    if (exp_halt) begin
      chk("misalign_set", 32'(bus.misalign), 32'd1);
      chk("halt_pc", bus.pc, exp_pc);
      for (int i = 0; i < 6; i++) begin
        bus.imem_rvalid = 1'($urandom);
        bus.instr_ready = 1'($urandom);
        @(negedge clk);
        chk("halt_req", 32'(bus.imem_req), 32'd0);
        chk("halt_valid", 32'(bus.instr_valid), 32'd0);
        chk("halt_misalign", 32'(bus.misalign), 32'd1);
      end
      bus.imem_rvalid = 1'b0;
      bus.instr_ready = 1'b0;
    end else begin
      chk("misalign_clr", 32'(bus.misalign), 32'd0);
      chk("next_req", 32'(bus.imem_req), 32'd1);
      chk("next_addr", bus.imem_addr, src ? tgt : exp_pc + 32'd4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] mpc;
    logic [31:0] r;
    bit src;
    bit seen;

    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    bus.pc_src = 1'b0;
    bus.pc_target = 32'h0;
    bus2.imem_rvalid = 1'b0;
    bus2.imem_rdata = 32'h0;
    bus2.instr_ready = 1'b0;
    bus2.pc_src = 1'b0;
    bus2.pc_target = 32'h0;

    tbl[0] = '{1, 32'h0050_0093, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[1] = '{0, 32'h0010_0113, 5, 1'b0, 32'h0000_0103, 32'h0000_0004, 1'b0};
    tbl[2] = '{2, 32'h0020_8193, 0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
    tbl[3] = '{0, 32'h0000_0063, 1, 1'b0, 32'h0000_0000, 32'h0000_000C, 1'b0};
    tbl[4] = '{1, 32'h0400_006F, 0, 1'b1, 32'h0000_0040, 32'h0000_0010, 1'b0};
    tbl[5] = '{0, 32'h0000_0013, 2, 1'b0, 32'h0000_0042, 32'h0000_0040, 1'b0};
    tbl[6] = '{3, 32'h0120_00E7, 0, 1'b1, 32'h0000_0022, 32'h0000_0044, 1'b1};

    do_reset();
    for (int k = 0; k < 7; k++)
      txn(tbl[k].lat, tbl[k].rdata, tbl[k].rdy, tbl[k].src, tbl[k].tgt, tbl[k].pc, tbl[k].halt);

    // Leave HALT through reset; do_reset checks misalign and address.
    do_reset();

    // Reset in the middle of WAIT with a stale response arriving around it.
    wait_req(ok);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    exp_cnt = 0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("stale_req", 32'(bus.imem_req), 32'd1);
    chk("stale_addr", bus.imem_addr, 32'h0);
    chk("stale_valid", 32'(bus.instr_valid), 32'd0);
    chk("stale_instr", bus.instr, NOP);
    bus.imem_rvalid = 1'b0;
    txn(0, 32'h0030_0213, 0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Randomized transactions against the PC/count model.
    mpc = 32'h4;
    for (int k = 0; k < 30; k++) begin
      r = $urandom;
      src = ($urandom_range(0, 2) == 0);
      if (src) r = {r[31:2], 2'b00};
      txn($urandom_range(0, 3), $urandom, $urandom_range(0, 3), src, r, mpc, 1'b0);
      mpc = src ? r : mpc + 32'd4;
    end

    // PC and retire counter wrap on the second instance.
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus2.imem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wrap_req_seen", 32'(seen), 32'd1);
    chk("wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", bus2.pc_plus4, 32'h0000_0000);
    @(negedge clk);
    bus2.imem_rvalid = 1'b1;
    bus2.imem_rdata = 32'h0000_0033;
    @(negedge clk);
    bus2.imem_rvalid = 1'b0;
    chk("wrap_valid", 32'(bus2.instr_valid), 32'd1);
    force dut2.retire_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    release dut2.retire_cnt_q;
    chk("wrap_cnt_pre", bus2.retire_cnt, 32'hFFFF_FFFF);
    bus2.instr_ready = 1'b1;
    bus2.pc_src = 1'b0;
    bus2.pc_target = 32'h0000_0100;
    @(negedge clk);
    bus2.instr_ready = 1'b0;
    chk("wrap_cnt", bus2.retire_cnt, 32'h0);
    chk("wrap_next_req", 32'(bus2.imem_req), 32'd1);
    chk("wrap_next_addr", bus2.imem_addr, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
